// File: rtl/sw_cond_pkg.sv
// Shared types and default sizing for the switch input conditioner.
package sw_cond_pkg;

  typedef enum logic {
    S_STABLE = 1'b0,
    S_SETTLE = 1'b1
  } sw_state_e;

  localparam int unsigned DefaultWidth          = 8;
  localparam int unsigned DefaultDebounceCycles = 16;
  localparam int unsigned DefaultCntW           = 5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of asynchronous levels.
module sync_2ff #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = d_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/sw_input_conditioner.sv
// Synchronises and debounces the switch bus as one word, then offers each
// committed word to the processor over a valid/ready handshake.
module sw_input_conditioner
  import sw_cond_pkg::*;
#(
  parameter int unsigned WIDTH           = DefaultWidth,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned CNT_W           = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic             sw_valid,
  input  logic             sw_ready,
  output logic             sw_changed,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync2;

  sync_2ff #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sw_raw),
    .q_o   (sync2)
  );

  sw_state_e        state_q, state_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sw_out_q, sw_out_d;
  logic             sw_valid_q, sw_valid_d;
  logic             sw_changed_q, sw_changed_d;
  logic             overrun_q, overrun_d;
  logic             commit;

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    sw_out_d = sw_out_q;
    commit   = 1'b0;

    unique case (state_q)
      S_STABLE: begin
        if (sync2 != stable_q) begin
          cand_d  = sync2;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (sync2 == stable_q) begin
          state_d = S_STABLE;
        end else if (sync2 != cand_q) begin
          // Any bit moving restarts the window, so the word commits atomically.
          cand_d = sync2;
          cnt_d  = '0;
        end else if (cnt_q == CntMax) begin
          commit  = 1'b1;
          state_d = S_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    if (commit) begin
      stable_d = cand_q;
      sw_out_d = cand_q;
    end

    // A commit always wins over acceptance; the newest word is what gets offered.
    if (commit) begin
      sw_valid_d = 1'b1;
    end else if (sw_valid_q && sw_ready) begin
      sw_valid_d = 1'b0;
    end else begin
      sw_valid_d = sw_valid_q;
    end

    sw_changed_d = commit;
    overrun_d    = commit && sw_valid_q && !sw_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_STABLE;
      stable_q     <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      sw_out_q     <= '0;
      sw_valid_q   <= 1'b0;
      sw_changed_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stable_q     <= stable_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      sw_out_q     <= sw_out_d;
      sw_valid_q   <= sw_valid_d;
      sw_changed_q <= sw_changed_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sw_out     = sw_out_q;
  assign sw_valid   = sw_valid_q;
  assign sw_changed = sw_changed_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner with a 4-cycle debounce window.
module tb_sw_input_conditioner;

  localparam int unsigned Width = 8;

  logic             clk;
  logic             rst_n;
  logic [Width-1:0] sw_raw;
  logic [Width-1:0] sw_out;
  logic             sw_valid;
  logic             sw_ready;
  logic             sw_changed;
  logic             overrun;

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

  sw_input_conditioner #(
    .WIDTH           (Width),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_out     (sw_out),
    .sw_valid   (sw_valid),
    .sw_ready   (sw_ready),
    .sw_changed (sw_changed),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    sw_raw   = 8'hA;
    sw_ready = 1'b0;

    // 1. Word held through reset release
    step(2);
    check_eq("rst_out", 32'(sw_out), 32'h0);
    check_eq("rst_valid", 32'(sw_valid), 32'h0);
    check_eq("rst_changed", 32'(sw_changed), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    step(6);
    check_eq("t1_not_early_valid", 32'(sw_valid), 32'h0);
    check_eq("t1_not_early_out", 32'(sw_out), 32'h0);
    step(1);
    check_eq("t1_out", 32'(sw_out), 32'hA);
    check_eq("t1_valid", 32'(sw_valid), 32'h1);
    check_eq("t1_changed", 32'(sw_changed), 32'h1);
    check_eq("t1_overrun", 32'(overrun), 32'h0);
    step(1);
    check_eq("t1_changed_pulse", 32'(sw_changed), 32'h0);
    check_eq("t1_valid_hold", 32'(sw_valid), 32'h1);

    // 2. Two-cycle glitch is rejected
    sw_raw = 8'hF;
    step(2);
    sw_raw = 8'hA;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      pulses += int'(sw_changed) + int'(overrun);
    end
    check_eq("t2_pulses", 32'(pulses), 32'h0);
    check_eq("t2_out", 32'(sw_out), 32'hA);
    check_eq("t2_valid", 32'(sw_valid), 32'h1);

    // 3. Commit over an unaccepted word raises overrun
    sw_raw = 8'h0;
    step(6);
    check_eq("t3_out_held", 32'(sw_out), 32'hA);
    step(1);
    check_eq("t3_out", 32'(sw_out), 32'h0);
    check_eq("t3_valid", 32'(sw_valid), 32'h1);
    check_eq("t3_changed", 32'(sw_changed), 32'h1);
    check_eq("t3_overrun", 32'(overrun), 32'h1);
    step(1);
    check_eq("t3_overrun_pulse", 32'(overrun), 32'h0);

    // 4. Acceptance on the commit edge: no overrun, new word stays valid
    sw_raw = 8'hF;
    step(6);
    sw_ready = 1'b1;
    step(1);
    check_eq("t4_out", 32'(sw_out), 32'hF);
    check_eq("t4_valid", 32'(sw_valid), 32'h1);
    check_eq("t4_overrun", 32'(overrun), 32'h0);
    check_eq("t4_changed", 32'(sw_changed), 32'h1);
    step(1);
    check_eq("t4_accept", 32'(sw_valid), 32'h0);
    sw_ready = 1'b0;
    step(2);
    check_eq("t4_idle_valid", 32'(sw_valid), 32'h0);

    // 5. Reset mid-settle with a word pending
    sw_raw = 8'h5;
    step(7);
    check_eq("t5_pre_out", 32'(sw_out), 32'h5);
    check_eq("t5_pre_valid", 32'(sw_valid), 32'h1);
    sw_raw = 8'hC;
    step(4);
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_out", 32'(sw_out), 32'h0);
    check_eq("t5_async_valid", 32'(sw_valid), 32'h0);
    check_eq("t5_async_changed", 32'(sw_changed), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(6);
    check_eq("t5_no_partial", 32'(sw_valid), 32'h0);
    step(1);
    check_eq("t5_out", 32'(sw_out), 32'hC);
    check_eq("t5_valid", 32'(sw_valid), 32'h1);
    check_eq("t5_overrun", 32'(overrun), 32'h0);

    // 6. Skewed bit changes commit once, as the final word
    sw_ready = 1'b1;
    step(1);
    check_eq("t6_accept", 32'(sw_valid), 32'h0);
    sw_ready = 1'b0;
    sw_raw   = 8'hD;
    step(2);
    sw_raw = 8'h5;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      pulses += int'(sw_changed);
    end
    check_eq("t6_no_early", 32'(pulses), 32'h0);
    check_eq("t6_out_held", 32'(sw_out), 32'hC);
    step(1);
    check_eq("t6_out", 32'(sw_out), 32'h5);
    check_eq("t6_valid", 32'(sw_valid), 32'h1);
    check_eq("t6_changed", 32'(sw_changed), 32'h1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      pulses += int'(sw_changed);
    end
    check_eq("t6_single_commit", 32'(pulses), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
